// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-bit edge detector with one-deep pending events drained round-robin
//
// Purpose:
//   Watches every bit of a synchronised level vector for edges (rising, falling
//   or both, chosen by EDGE_MODE). Each edge becomes a one-deep pending event on
//   its bit; pending events are offered one at a time on a valid/ready port,
//   picked round-robin starting from the bit after the last accepted one.
//
// Ports:
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset
//   sig_in     in   WIDTH  monitored level vector
//   en         in   1      1 = capture new edges, 0 = ignore new edges (still drain)
//   clr_ovf    in   1      clears the sticky overflow flag
//   evt_valid  out  1      event offered
//   evt_ready  in   1      consumer accepts when evt_valid & evt_ready
//   evt_idx    out  IDX_W  bit index of the offered event
//   evt_rise   out  1      1 = rising edge, 0 = falling edge
//   pending    out  WIDTH  per-bit pending flags
//   overflow   out  1      sticky: an edge hit a bit that was already pending

module edge_event_arbiter #(
    parameter  int WIDTH     = 4,
    parameter  int EDGE_MODE = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    input  logic             en,
    input  logic             clr_ovf,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_rise,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sig_prev;
    logic             r_armed;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_pend_pol;
    logic [IDX_W-1:0] r_ptr;
    logic             r_evt_valid;
    logic [IDX_W-1:0] r_evt_idx;
    logic             r_evt_rise;
    logic             r_overflow;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_mask;
    logic [WIDTH-1:0] w_capture;
    logic [WIDTH-1:0] w_drop;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [WIDTH-1:0] w_pend_pol_nxt;
    logic             w_overflow_nxt;

    logic [IDX_W-1:0] w_cand [WIDTH];
    logic [IDX_W-1:0] w_pick_idx;

    logic             w_evt_valid_nxt;
    logic [IDX_W-1:0] w_evt_idx_nxt;
    logic             w_evt_rise_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;

    // Edge detect against the previous sample. Nothing fires until one
    // post-reset sample has been taken, so a vector that is already high
    // when reset releases never looks like an edge.
    assign w_rise = sig_in & ~r_sig_prev & {WIDTH{r_armed}};
    assign w_fall = ~sig_in & r_sig_prev & {WIDTH{r_armed}};

    always_comb begin
        w_edge = '0;
        if (EDGE_MODE == 0) begin
            w_edge = w_rise;
        end else if (EDGE_MODE == 1) begin
            w_edge = w_fall;
        end else begin
            w_edge = w_rise | w_fall;
        end
        w_edge = w_edge & {WIDTH{en}};
    end

    assign w_accept   = (r_state == S_OFFER) && r_evt_valid && evt_ready;
    assign w_acc_mask = w_accept ? (WIDTH'(1) << r_evt_idx) : '0;

    // A bit accepted this cycle counts as free, so a new edge on it is
    // re-captured instead of being reported as an overflow.
    assign w_capture      = w_edge & (~r_pending | w_acc_mask);
    assign w_drop         = w_edge & r_pending & ~w_acc_mask;
    assign w_pending_nxt  = (r_pending & ~w_acc_mask) | w_capture;
    assign w_pend_pol_nxt = (r_pend_pol & ~w_capture) | (w_rise & w_capture);

    // Setting wins over clearing so a drop in the clear cycle is not lost.
    assign w_overflow_nxt = (|w_drop) ? 1'b1 : (clr_ovf ? 1'b0 : r_overflow);

    // Round-robin search: candidate k is bit (ptr + k) mod WIDTH. Scanning
    // from the far end lets the nearest pending candidate win.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_cand[k] = IDX_W'((int'(r_ptr) + k) % WIDTH);
        end
        w_pick_idx = r_ptr;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (r_pending[w_cand[k]]) begin
                w_pick_idx = w_cand[k];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_evt_valid_nxt = r_evt_valid;
        w_evt_idx_nxt   = r_evt_idx;
        w_evt_rise_nxt  = r_evt_rise;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_evt_valid_nxt = 1'b1;
                    w_evt_idx_nxt   = w_pick_idx;
                    w_evt_rise_nxt  = r_pend_pol[w_pick_idx];
                    w_state_nxt     = S_OFFER;
                end
            end
            S_OFFER: begin
                if (w_accept) begin
                    w_evt_valid_nxt = 1'b0;
                    w_ptr_nxt       = (r_evt_idx == IDX_W'(WIDTH - 1)) ? '0
                                                                       : r_evt_idx + IDX_W'(1);
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_evt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sig_prev  <= '0;
            r_armed     <= 1'b0;
            r_pending   <= '0;
            r_pend_pol  <= '0;
            r_ptr       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_evt_rise  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sig_prev  <= sig_in;
            r_armed     <= 1'b1;
            r_pending   <= w_pending_nxt;
            r_pend_pol  <= w_pend_pol_nxt;
            r_ptr       <= w_ptr_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_idx   <= w_evt_idx_nxt;
            r_evt_rise  <= w_evt_rise_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign evt_rise  = r_evt_rise;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - testbench for edge_event_arbiter in all three edge modes
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       clr_ovf = 1'b0;
    logic       evt_ready = 1'b0;
    logic [3:0] sig_in = 4'b0000;

    logic       o_valid [3];
    logic [1:0] o_idx   [3];
    logic       o_rise  [3];
    logic [3:0] o_pend  [3];
    logic       o_ovf   [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            edge_event_arbiter #(.WIDTH(4), .EDGE_MODE(g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .sig_in    (sig_in),
                .en        (en),
                .clr_ovf   (clr_ovf),
                .evt_valid (o_valid[g]),
                .evt_ready (evt_ready),
                .evt_idx   (o_idx[g]),
                .evt_rise  (o_rise[g]),
                .pending   (o_pend[g]),
                .overflow  (o_ovf[g])
            );
        end
    endgenerate

    always @(posedge clk) begin
        if (!rst) assert (!$isunknown(sig_in));
    end

    // Reference model: one entry per edge mode (0 rise, 1 fall, 2 both).
    logic [3:0] m_prev [3];
    logic [3:0] m_pend [3];
    logic [3:0] m_pol  [3];
    logic       m_armed[3];
    logic       m_valid[3];
    logic       m_rise [3];
    logic       m_ovf  [3];
    int         m_ptr  [3];
    int         m_idx  [3];

    task automatic model_step(input int m);
        logic [3:0] r, f, e, np, npol;
        bit acc, drop;
        if (rst) begin
            m_prev[m] = 0; m_pend[m] = 0; m_pol[m] = 0; m_armed[m] = 0;
            m_valid[m] = 0; m_rise[m] = 0; m_ovf[m] = 0; m_ptr[m] = 0; m_idx[m] = 0;
            return;
        end
        acc = m_valid[m] && evt_ready;
        r = m_armed[m] ? (sig_in & ~m_prev[m]) : 4'b0;
        f = m_armed[m] ? (~sig_in & m_prev[m]) : 4'b0;
        e = (m == 0) ? r : ((m == 1) ? f : (r | f));
        if (!en) e = 0;
        np = m_pend[m];
        npol = m_pol[m];
        drop = 0;
        for (int i = 0; i < 4; i++) begin
            bit acc_i;
            acc_i = acc && (m_idx[m] == i);
            if (acc_i) np[i] = 0;
            if (e[i]) begin
                if (!m_pend[m][i] || acc_i) begin
                    np[i] = 1;
                    npol[i] = r[i];
                end else begin
                    drop = 1;
                end
            end
        end
        if (m_valid[m]) begin
            if (acc) begin
                m_valid[m] = 0;
                m_ptr[m] = (m_idx[m] + 1) % 4;
            end
        end else if (m_pend[m] != 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr[m] + k) % 4;
                if (m_pend[m][j]) begin
                    m_idx[m] = j;
                    break;
                end
            end
            m_rise[m] = m_pol[m][m_idx[m]];
            m_valid[m] = 1;
        end
        m_pend[m] = np;
        m_pol[m] = npol;
        if (drop) m_ovf[m] = 1;
        else if (clr_ovf) m_ovf[m] = 0;
        m_prev[m] = sig_in;
        m_armed[m] = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int m = 0; m < 3; m++) model_step(m);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] s);
        rst = 1; sig_in = s; en = 1; clr_ovf = 0; evt_ready = 0;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; sig_in = 4'b1111; en = 1; evt_ready = 1; clr_ovf = 0;
        tick(); tick();
        for (int m = 0; m < 3; m++) begin
            n_tests++;
            if ({o_valid[m], o_idx[m], o_rise[m], o_pend[m], o_ovf[m]} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset mode=%0d: valid=%b idx=%0d rise=%b pend=%b ovf=%b, want all 0",
                         m, o_valid[m], o_idx[m], o_rise[m], o_pend[m], o_ovf[m]);
            end
        end
        rst = 0;
    endtask

    task automatic test_toggle();
        int cnt [3];
        do_reset(4'b0100);
        evt_ready = 1;
        cnt = '{0, 0, 0};
        for (int c = 0; c < 30; c++) begin
            if (c < 24) sig_in = (c % 2 == 0) ? 4'b0101 : 4'b0100;
            tick();
            for (int m = 0; m < 2; m++) begin
                if (o_valid[m]) begin
                    cnt[m]++;
                    n_tests++;
                    if (o_idx[m] !== 2'd0 || o_rise[m] !== (m == 0)) begin
                        n_fail++;
                        $display("FAIL toggle_evt mode=%0d c=%0d: idx=%0d rise=%b, want idx=0 rise=%b",
                                 m, c, o_idx[m], o_rise[m], m == 0);
                    end
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (cnt[m] != 12 || o_ovf[m] !== 1'b0) begin
                n_fail++;
                $display("FAIL toggle_count mode=%0d: events=%0d ovf=%b, want events=12 ovf=0",
                         m, cnt[m], o_ovf[m]);
            end
        end
    endtask

    task automatic test_all_rise();
        int q[$];
        do_reset(4'b0000);
        evt_ready = 1;
        sig_in = 4'b1111;
        tick();
        n_tests++;
        if (o_pend[0] !== 4'b1111) begin
            n_fail++;
            $display("FAIL all_rise_pend: pending=%b, want 1111", o_pend[0]);
        end
        for (int c = 0; c < 8; c++) begin
            if (o_valid[0]) q.push_back(int'(o_idx[0]));
            tick();
        end
        n_tests++;
        if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3 || o_pend[0] !== 4'b0) begin
            n_fail++;
            $display("FAIL all_rise_order: got %p pend=%b, want 0 1 2 3 pend=0000", q, o_pend[0]);
        end
    endtask

    task automatic test_stall();
        int q[$];
        do_reset(4'b0000);
        evt_ready = 0;
        sig_in = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (o_valid[0] !== 1'b1 || o_idx[0] !== 2'd0 || o_rise[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold c=%0d: valid=%b idx=%0d rise=%b, want 1 0 1",
                         c, o_valid[0], o_idx[0], o_rise[0]);
            end
        end
        evt_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (o_valid[0]) q.push_back(int'(o_idx[0]));
            tick();
        end
        n_tests++;
        if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3 || o_pend[0] !== 4'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got %p pend=%b, want 0 1 2 3 pend=0000", q, o_pend[0]);
        end
    endtask

    task automatic test_overflow();
        do_reset(4'b0000);
        evt_ready = 0;
        sig_in = 4'b0100;
        tick();
        sig_in = 4'b0000;
        tick();
        n_tests++;
        if (o_valid[2] !== 1'b1 || o_idx[2] !== 2'd2 || o_rise[2] !== 1'b1 || o_ovf[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: valid=%b idx=%0d rise=%b ovf=%b, want 1 2 1 1",
                     o_valid[2], o_idx[2], o_rise[2], o_ovf[2]);
        end
        n_tests++;
        if (o_ovf[0] !== 1'b0 || o_pend[2] !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_other: mode0 ovf=%b mode2 pend=%b, want 0 0100", o_ovf[0], o_pend[2]);
        end
        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        n_tests++;
        if (o_ovf[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b, want 0", o_ovf[2]);
        end
        evt_ready = 1;
        tick(); tick();
    endtask

    task automatic test_reaccept();
        int q[$];
        bit hit;
        do_reset(4'b0000);
        evt_ready = 1;
        sig_in = 4'b1111;
        tick();
        sig_in = 4'b1101;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (o_valid[0] && o_idx[0] == 2'd1) hit = 1;
            else tick();
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reaccept_wait: idx 1 never offered, want offer within 20 cycles");
        end
        sig_in = 4'b1111;
        tick();
        n_tests++;
        if (o_pend[0][1] !== 1'b1 || o_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reaccept_pend: pend=%b ovf=%b, want bit1=1 ovf=0", o_pend[0], o_ovf[0]);
        end
        for (int c = 0; c < 8; c++) begin
            if (o_valid[0]) q.push_back(int'(o_idx[0]));
            tick();
        end
        n_tests++;
        if (q.size() != 3 || q[0] != 2 || q[1] != 3 || q[2] != 1) begin
            n_fail++;
            $display("FAIL reaccept_order: got %p, want 2 3 1", q);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'b0000);
        evt_ready = 0;
        sig_in = 4'b1010;
        tick(); tick();
        n_tests++;
        if (o_valid[0] !== 1'b1 || o_pend[0] !== 4'b1010) begin
            n_fail++;
            $display("FAIL midrst_pre: valid=%b pend=%b, want 1 1010", o_valid[0], o_pend[0]);
        end
        rst = 1;
        sig_in = 4'b1111;
        tick();
        for (int m = 0; m < 3; m++) begin
            n_tests++;
            if ({o_valid[m], o_idx[m], o_rise[m], o_pend[m], o_ovf[m]} !== 9'b0) begin
                n_fail++;
                $display("FAIL midrst_clear mode=%0d: valid=%b idx=%0d rise=%b pend=%b ovf=%b, want all 0",
                         m, o_valid[m], o_idx[m], o_rise[m], o_pend[m], o_ovf[m]);
            end
        end
        rst = 0;
        evt_ready = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                n_tests++;
                if (o_valid[m] !== 1'b0 || o_pend[m] !== 4'b0) begin
                    n_fail++;
                    $display("FAIL midrst_quiet mode=%0d c=%0d: valid=%b pend=%b, want 0 0000",
                             m, c, o_valid[m], o_pend[m]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset(4'($urandom));
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) sig_in = 4'($urandom);
            en        = ($urandom_range(0, 4) != 0);
            evt_ready = ($urandom_range(0, 4) < 3);
            clr_ovf   = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
            for (int m = 0; m < 3; m++) begin
                n_tests++;
                if (o_valid[m] !== m_valid[m] || o_pend[m] !== m_pend[m] || o_ovf[m] !== m_ovf[m] ||
                    (m_valid[m] && (o_idx[m] !== 2'(m_idx[m]) || o_rise[m] !== m_rise[m]))) begin
                    n_fail++;
                    $display("FAIL random mode=%0d c=%0d: valid=%b pend=%b ovf=%b idx=%0d rise=%b, want valid=%b pend=%b ovf=%b idx=%0d rise=%b",
                             m, c, o_valid[m], o_pend[m], o_ovf[m], o_idx[m], o_rise[m],
                             m_valid[m], m_pend[m], m_ovf[m], m_idx[m], m_rise[m]);
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            m_prev[m] = 0; m_pend[m] = 0; m_pol[m] = 0; m_armed[m] = 0;
            m_valid[m] = 0; m_rise[m] = 0; m_ovf[m] = 0; m_ptr[m] = 0; m_idx[m] = 0;
        end
        test_reset();
        test_toggle();
        test_all_rise();
        test_stall();
        test_overflow();
        test_reaccept();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
